// File: rtl/mux4_1_pkg.sv
// Shared select encoding for the registered 4-to-1 multiplexer.
package mux4_1_pkg;

  typedef logic [1:0] mux_sel_t;

  localparam mux_sel_t SEL_I0 = 2'b00;
  localparam mux_sel_t SEL_I1 = 2'b01;
  localparam mux_sel_t SEL_I2 = 2'b10;
  localparam mux_sel_t SEL_I3 = 2'b11;

endpackage

// File: rtl/mux4_1_sel.sv
// Purely combinational WIDTH-bit 4-to-1 selector; no state, no clock.
module mux4_1_sel
  import mux4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  mux_sel_t         sel,
  output logic [WIDTH-1:0] y
);

  // Unselected inputs never reach y, so X/Z on them cannot leak through.
  always_comb begin
    y = i0;
    case (sel)
      SEL_I0: y = i0;
      SEL_I1: y = i1;
      SEL_I2: y = i2;
      SEL_I3: y = i3;
    endcase
  end

endmodule

// File: rtl/mux4_1.sv
// Registered 4-to-1 multiplexer with valid qualifier.
// Define MUX4_1_PASSTHRU_EN for a zero-latency combinational build.
module mux4_1
  import mux4_1_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic             s1,
  input  logic             s0,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out,
  output logic             out_vld
);

  mux_sel_t         sel;
  logic [WIDTH-1:0] sel_data;

  assign sel = {s1, s0};

  mux4_1_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .i0 (i0),
    .i1 (i1),
    .i2 (i2),
    .i3 (i3),
    .sel(sel),
    .y  (sel_data)
  );

`ifdef MUX4_1_PASSTHRU_EN
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign out     = sel_data;
  assign out_vld = in_vld;
`else
  // Reset wins over in_vld; out holds its last value while in_vld is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      out     <= '0;
      out_vld <= 1'b0;
    end else begin
      out_vld <= in_vld;
      if (in_vld) begin
        out <= sel_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mux4_1.sv
// Bench for mux4_1: directed cases plus random traffic against a reference model.
module tb_mux4_1;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] i0, i1, i2, i3;
  logic         s1, s0;
  logic         in_vld;
  logic [W-1:0] out;
  logic         out_vld;

  logic [W:0]   exp_q[$];
  logic [W-1:0] mdl_out;
  logic         mdl_vld;
  int           n_cmp;
  int           n_err;

  mux4_1 #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .i0     (i0),
    .i1     (i1),
    .i2     (i2),
    .i3     (i3),
    .s1     (s1),
    .s0     (s0),
    .in_vld (in_vld),
    .out    (out),
    .out_vld(out_vld)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: selected source is element s1*2+s0 of the four inputs.
  function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] a,
                                        input logic [W-1:0] b, input logic [W-1:0] c,
                                        input logic [W-1:0] d);
    logic [W-1:0] src[4];
    src[0] = a; src[1] = b; src[2] = c; src[3] = d;
    return src[int'(s[1]) * 2 + int'(s[0])];
  endfunction

  // driver: apply one cycle of stimulus, predict, then compare
  task automatic step(input string tag, input logic r, input logic v, input logic [1:0] s,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    logic [W:0] e;
    @(negedge clk);
    rst = r; in_vld = v; s1 = s[1]; s0 = s[0];
    i0 = a; i1 = b; i2 = c; i3 = d;
`ifdef MUX4_1_PASSTHRU_EN
    #1;
    exp_q.push_back({v, pick(s, a, b, c, d)});
`else
    @(posedge clk);
    if (r) begin
      mdl_out = '0;
      mdl_vld = 1'b0;
    end else begin
      mdl_vld = v;
      if (v) mdl_out = pick(s, a, b, c, d);
    end
    exp_q.push_back({mdl_vld, mdl_out});
    #1;
`endif
    e = exp_q.pop_front();
    check({tag, ".out"}, out, e[W-1:0]);
    check({tag, ".vld"}, W'(out_vld), W'(e[W]));
  endtask

  logic [W-1:0] one;
  logic [W-1:0] zro;

  initial begin
    n_cmp = 0; n_err = 0;
    mdl_out = '0; mdl_vld = 1'b0;
    one = W'(1); zro = '0;
    rst = 1'b1; in_vld = 1'b0; s1 = 1'b0; s0 = 1'b0;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;

    // reset held two cycles with valid data present
    step("rst_a", 1, 1, 2'b00, one, zro, zro, zro);
    step("rst_b", 1, 1, 2'b00, one, zro, zro, zro);

    step("sel3_zero", 0, 1, 2'b11, one, zro, zro, zro);
    step("sel3_one", 0, 1, 2'b11, zro, zro, zro, one);

    // one-hot sweep, then inverted data
    step("sweep0", 0, 1, 2'b00, one, zro, zro, zro);
    step("sweep1", 0, 1, 2'b01, zro, one, zro, zro);
    step("sweep2", 0, 1, 2'b10, zro, zro, one, zro);
    step("sweep3", 0, 1, 2'b11, zro, zro, zro, one);
    step("inv0", 0, 1, 2'b00, ~one, ~zro, ~zro, ~zro);
    step("inv1", 0, 1, 2'b01, ~zro, ~one, ~zro, ~zro);
    step("inv2", 0, 1, 2'b10, ~zro, ~zro, ~one, ~zro);
    step("inv3", 0, 1, 2'b11, ~zro, ~zro, ~zro, ~one);

    // hold while in_vld low and inputs move
    step("load1", 0, 1, 2'b10, zro, zro, one, zro);
    step("hold_a", 0, 0, 2'b00, 8'h5a, zro, zro, zro);
    step("hold_b", 0, 0, 2'b01, zro, 8'ha5, zro, zro);

    // reset coincident with valid input
    step("rst_vld", 1, 1, 2'b11, zro, zro, zro, one);
    step("post_rst_idle", 0, 0, 2'b11, zro, zro, zro, one);
    step("post_rst_first", 0, 1, 2'b11, zro, zro, zro, 8'h3c);

    // X on unselected inputs
    step("x_unsel0", 0, 1, 2'b00, 8'h81, 'x, 'x, 'x);
    step("x_unsel3", 0, 1, 2'b11, 'x, 'x, 'x, 8'h7e);

`ifndef MUX4_1_PASSTHRU_EN
    // inputs wiggling between edges must not reach out
    step("pre_glitch", 0, 1, 2'b01, zro, 8'hc3, zro, zro);
    #1;
    in_vld = 1'b1; s1 = 1'b1; s0 = 1'b0; i2 = 8'hff; i1 = 8'h00;
    #1;
    check("glitch.out", out, 8'hc3);
`endif

    for (int k = 0; k < 300; k++) begin
      step("rand", ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)), W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux4_1.md
# mux4_1

Registered 4-to-1 multiplexer with a valid qualifier. It selects one of four equal-width data inputs using a two-bit select (`s1`, `s0`) and presents the result on `out`. It is the basic data-steering element in the datapath: it feeds downstream registered logic and is instantiated wherever four sources share one sink.

## Interface
Parameters:
- `WIDTH`, default 1: width of each data input and of `out`.

Ports:
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `i0`  input  WIDTH  data source, selected when s1,s0 = 0,0.
- `i1`  input  WIDTH  data source, selected when s1,s0 = 0,1.
- `i2`  input  WIDTH  data source, selected when s1,s0 = 1,0.
- `i3`  input  WIDTH  data source, selected when s1,s0 = 1,1.
- `s1`  input  1  select MSB.
- `s0`  input  1  select LSB.
- `in_vld`  input  1  inputs and select are meaningful this cycle.
- `out`  output  WIDTH  selected data.
- `out_vld`  output  1  `out` holds a valid selection.

## Operation
- Select index is {s1,s0}:
  - 0 → i0
  - 1 → i1
  - 2 → i2
  - 3 → i3
- All four encodings are legal. There is no default or error case.
- On a rising edge with `rst`=0 and `in_vld`=1: `out` takes the selected input, and `out_vld` becomes 1.
- On a rising edge with `rst`=0 and `in_vld`=0: `out` holds its previous value, and `out_vld` becomes 0.
- Selection is bitwise across all WIDTH bits. There is no arithmetic and no width conversion.
- X/Z on an unselected input must not affect `out`.

## Timing
- Latency is 1 cycle. Inputs sampled at edge N appear on `out` and `out_vld` after edge N and remain stable until edge N+1.
- Reset values: `out` = 0 (all WIDTH bits) and `out_vld` = 0.
- `rst` dominates. If `rst`=1 and `in_vld`=1 on the same edge, the result is the reset values and the input is discarded.
- Reset asserted mid-stream clears the in-flight result on that edge. The first valid output after reset appears one cycle after the first `in_vld`=1 edge with `rst`=0.
- Input changes between edges have no effect on `out`. There is no combinational input-to-output path in the default build.
- Back-to-back valid inputs produce back-to-back valid outputs, one per cycle, with no bubbles.

## Configuration
- Macro `MUX4_1_PASSTHRU_EN`. When defined, `out` is driven combinationally from the selector:
  - zero latency, with `out` following the inputs within the same cycle;
  - `out_vld` = `in_vld` combinationally;
  - `clk` and `rst` are unused.
- When undefined (default), behaviour is fully registered as described above.

## Structure
- Package `mux4_1_pkg`:
  - select-encoding constants `SEL_I0`=2'b00, `SEL_I1`=2'b01, `SEL_I2`=2'b10, `SEL_I3`=2'b11;
  - a 2-bit select typedef `mux_sel_t`.
- Sub-module `mux4_1_sel`: purely combinational WIDTH-parameterised selector taking i0–i3 and `mux_sel_t`. The top level adds the output register, the valid register and the passthrough option.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_vld`=1 and i0=1, s1,s0=0,0 → `out`=0 and `out_vld`=0 throughout the reset.
- i0=1, i1=0, i2=0, i3=0, s1,s0=1,1, `in_vld`=1 → `out`=0 and `out_vld`=1 one cycle later.
- i0=0, i1=0, i2=0, i3=1, s1,s0=1,1, `in_vld`=1 → `out`=1 one cycle later.
- Sweep s1,s0 over 00, 01, 10, 11 with one-hot inputs (i0=1, i1=1, i2=1, i3=1 respectively, others 0), one per cycle → `out`=1 on four consecutive cycles. Repeat with inverted data → `out`=0 on four consecutive cycles.
- `in_vld` dropped after `out`=1 while s1,s0 and the inputs change → `out` holds 1 and `out_vld`=0.
- `rst`=1 coincident with `in_vld`=1 and i3=1, s1,s0=1,1 → `out`=0 and `out_vld`=0. With `MUX4_1_PASSTHRU_EN` defined, the same stimulus gives `out`=1 in the same cycle.
